// File: rtl/multicycle_ctrl_pkg.sv
// Shared state encoding, RV32I opcodes and datapath select codes for the multicycle control FSM.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECR   = 4'd7,
    S_EXECI   = 4'd8,
    S_LUI     = 4'd9,
    S_ALUWB   = 4'd10,
    S_BRANCH  = 4'd11,
    S_JALRADR = 4'd12,
    S_JAL     = 4'd13,
    S_HALT    = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive ready-low cycles of a memory request; pulses o_timeout on the last tolerated one.
// MEM_WAIT_MAX = 0 disables the timeout entirely.
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_count_en,
  input  logic i_ready,
  output logic o_timeout
);

  localparam int unsigned CW    = (MEM_WAIT_MAX > 2) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam int unsigned LIMIT = (MEM_WAIT_MAX == 0) ? 0 : MEM_WAIT_MAX - 1;
  localparam logic [CW-1:0] LIMIT_W = LIMIT[CW-1:0];

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en && !i_ready) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Ready on the final cycle suppresses the pulse, so a late completion still wins.
  assign o_timeout = (MEM_WAIT_MAX != 0) && i_count_en && !i_ready && (r_count == LIMIT_W);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core with a memory-ready watchdog.
// Optional macro ILLEGAL_TRAP_EN: unlisted opcodes halt the core and set sticky o_Illegal.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_opcode,
  input  logic       i_mem_ready,
  output logic [1:0] o_ALUOp,
  output logic [1:0] o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic [1:0] o_ResultSrc,
  output logic       o_AdrSrc,
  output logic       o_MemReq,
  output logic       o_MemWrite,
  output logic       o_IRWrite,
  output logic       o_PCUpdate,
  output logic       o_Branch,
  output logic       o_RegWrite,
  output logic       o_Halted,
`ifdef ILLEGAL_TRAP_EN
  output logic       o_Illegal,
`endif
  output logic       o_MemTimeout
);

  state_t r_state;
  logic   r_memTimeout;
  logic   w_waitState;
  logic   w_timeout;
`ifdef ILLEGAL_TRAP_EN
  logic   r_illegal;
`endif

  assign w_waitState = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

  // Leaving a wait state only happens on ready or timeout, so this clear covers every state change.
  mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (!w_waitState || i_mem_ready),
    .i_count_en (w_waitState),
    .i_ready    (i_mem_ready),
    .o_timeout  (w_timeout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_memTimeout <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      r_illegal    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (i_mem_ready) begin
            r_state <= (r_state == S_FETCH) ? S_DECODE :
                       (r_state == S_MEMRD) ? S_MEMWB  : S_FETCH;
          end else if (w_timeout) begin
            r_state      <= S_HALT;
            r_memTimeout <= 1'b1;
          end
        end
        S_DECODE: begin
          case (i_opcode)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_RTYPE:          r_state <= S_EXECR;
            OP_ITYPE:          r_state <= S_EXECI;
            OP_BRANCH:         r_state <= S_BRANCH;
            OP_JAL:            r_state <= S_JAL;
            OP_JALR:           r_state <= S_JALRADR;
            OP_LUI:            r_state <= S_LUI;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              r_state   <= S_HALT;
              r_illegal <= 1'b1;
`else
              r_state   <= S_FETCH;
`endif
            end
          endcase
        end
        S_MEMADR:  r_state <= i_opcode[5] ? S_MEMWR : S_MEMRD;
        S_MEMWB:   r_state <= S_FETCH;
        S_EXECR:   r_state <= S_ALUWB;
        S_EXECI:   r_state <= S_ALUWB;
        S_LUI:     r_state <= S_ALUWB;
        S_ALUWB:   r_state <= S_FETCH;
        S_BRANCH:  r_state <= S_FETCH;
        S_JALRADR: r_state <= S_JAL;
        S_JAL:     r_state <= S_ALUWB;
        S_HALT:    r_state <= S_HALT;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ALUOp     = ALUOP_ADD;
    o_ALUSrcA   = SRCA_PC;
    o_ALUSrcB   = SRCB_RS2;
    o_ResultSrc = RES_ALUOUT;
    o_AdrSrc    = 1'b0;
    o_MemReq    = 1'b0;
    o_MemWrite  = 1'b0;
    o_IRWrite   = 1'b0;
    o_PCUpdate  = 1'b0;
    o_Branch    = 1'b0;
    o_RegWrite  = 1'b0;
    o_Halted    = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_MemReq    = 1'b1;
        o_ALUSrcB   = SRCB_FOUR;
        o_ResultSrc = RES_ALURESULT;
        o_IRWrite   = i_mem_ready;
        o_PCUpdate  = i_mem_ready;
      end
      S_DECODE: begin
        o_ALUSrcA = SRCA_OLDPC;
        o_ALUSrcB = SRCB_IMM;
      end
      S_MEMADR, S_JALRADR: begin
        o_ALUSrcA = SRCA_RS1;
        o_ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        o_MemReq = 1'b1;
        o_AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        o_ResultSrc = RES_MEMDATA;
        o_RegWrite  = 1'b1;
      end
      S_MEMWR: begin
        o_MemReq   = 1'b1;
        o_MemWrite = 1'b1;
        o_AdrSrc   = 1'b1;
      end
      S_EXECR: begin
        o_ALUSrcA = SRCA_RS1;
        o_ALUOp   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        o_ALUSrcA = SRCA_RS1;
        o_ALUSrcB = SRCB_IMM;
        o_ALUOp   = ALUOP_FUNCT;
      end
      S_LUI: begin
        o_ALUSrcA = SRCA_ZERO;
        o_ALUSrcB = SRCB_IMM;
      end
      S_ALUWB:  o_RegWrite = 1'b1;
      S_BRANCH: begin
        o_ALUSrcA = SRCA_RS1;
        o_ALUOp   = ALUOP_SUB;
        o_Branch  = 1'b1;
      end
      S_JAL: begin
        o_ALUSrcA  = SRCA_OLDPC;
        o_ALUSrcB  = SRCB_FOUR;
        o_PCUpdate = 1'b1;
      end
      S_HALT:  o_Halted = 1'b1;
      default: ;
    endcase
  end

  assign o_MemTimeout = r_memTimeout;
`ifdef ILLEGAL_TRAP_EN
  assign o_Illegal = r_illegal;
`endif

endmodule
